// File: rtl/gcd_lcm_coproc_if.sv
// Coprocessor port bundle for gcd_lcm_coproc.
// Master side issues Start/operands, slave side returns status/result.
interface gcd_lcm_coproc_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Mode;
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] OperandB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ReadData;
  logic             Overflow;

  modport master (
    output Start, Mode, OperandA, OperandB,
    input  Busy, Done, ReadData, Overflow
  );

  modport slave (
    input  Start, Mode, OperandA, OperandB,
    output Busy, Done, ReadData, Overflow
  );
endinterface

// File: rtl/gcd_lcm_coproc.sv
// Binary-GCD coprocessor; LCM path (DIV/MUL/Overflow) when
// COPROC_LCM_EN is defined.
module gcd_lcm_coproc #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset_n,
  gcd_lcm_coproc_if.slave bus
);
  localparam int KW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE, SHIFT, REDUCE, DIV, MUL, DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a, a_n;
  logic [WIDTH-1:0] b, b_n;
  logic [KW-1:0]    k, k_n;
  logic [WIDTH-1:0] res, res_n;
  logic [WIDTH-1:0] gval;
  logic             accept;
  logic             zero_op;

`ifdef COPROC_LCM_EN
  logic               mode;
  logic               ovf, ovf_n;
  logic [WIDTH-1:0]   opa, opb;
  logic [WIDTH-1:0]   g, g_n;
  logic [WIDTH-1:0]   rem, rem_n;
  logic [WIDTH-1:0]   quo, quo_n;
  logic [2*WIDTH-1:0] prod, prod_n;
  logic [KW-1:0]      cnt, cnt_n;
  logic [WIDTH:0]     rs;
  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     sum;
  localparam logic [KW-1:0] LAST = KW'(WIDTH - 1);
`endif

  assign accept  = bus.Start &&
                   (state == IDLE || state == DONE);
  assign zero_op = (bus.OperandA == '0) ||
                   (bus.OperandB == '0);
  assign gval    = a << k;

  assign bus.Busy     = (state == SHIFT) ||
                        (state == REDUCE) ||
                        (state == DIV) ||
                        (state == MUL);
  assign bus.Done     = (state == DONE);
  assign bus.ReadData = res;
`ifdef COPROC_LCM_EN
  assign bus.Overflow = ovf;
`else
  assign bus.Overflow = 1'b0;
`endif

  always_comb begin
    state_n = state;
    a_n     = a;
    b_n     = b;
    k_n     = k;
    res_n   = res;
`ifdef COPROC_LCM_EN
    ovf_n   = ovf;
    g_n     = g;
    rem_n   = rem;
    quo_n   = quo;
    prod_n  = prod;
    cnt_n   = cnt;
    rs      = '0;
    diff    = '0;
    sum     = '0;
`endif
    unique case (state)
      IDLE, DONE: begin
        if (state == DONE) state_n = IDLE;
        if (accept) begin
          a_n = bus.OperandA;
          b_n = bus.OperandB;
          k_n = '0;
          if (zero_op) begin
            state_n = DONE;
            res_n   = bus.OperandA | bus.OperandB;
`ifdef COPROC_LCM_EN
            ovf_n   = 1'b0;
            if (bus.Mode) res_n = '0;
`endif
          end else begin
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (!a[0] && !b[0]) begin
          a_n = a >> 1;
          b_n = b >> 1;
          k_n = k + 1'b1;
        end else begin
          state_n = REDUCE;
        end
      end
      REDUCE: begin
        if (b == '0) begin
          state_n = DONE;
          res_n   = gval;
`ifdef COPROC_LCM_EN
          ovf_n   = 1'b0;
          // LCM: keep old result visible until MUL ends
          if (mode) begin
            state_n = DIV;
            res_n   = res;
            ovf_n   = ovf;
            g_n     = gval;
            rem_n   = '0;
            quo_n   = opa;
            cnt_n   = '0;
          end
`endif
        end else if (!a[0]) begin
          a_n = a >> 1;
        end else if (!b[0]) begin
          b_n = b >> 1;
        end else if (a > b) begin
          a_n = (a - b) >> 1;
        end else begin
          b_n = (b - a) >> 1;
        end
      end
`ifdef COPROC_LCM_EN
      DIV: begin
        rs   = {rem, quo[WIDTH-1]};
        diff = rs - {1'b0, g};
        if (rs >= {1'b0, g}) begin
          rem_n = diff[WIDTH-1:0];
          quo_n = {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem_n = rs[WIDTH-1:0];
          quo_n = {quo[WIDTH-2:0], 1'b0};
        end
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) begin
          state_n = MUL;
          cnt_n   = '0;
          prod_n  = {{WIDTH{1'b0}}, opb};
        end
      end
      MUL: begin
        // multiplier sits in prod low half, shifts out
        sum = {1'b0, prod[2*WIDTH-1:WIDTH]} +
              (prod[0] ? {1'b0, quo} : '0);
        prod_n = {sum, prod[WIDTH-1:1]};
        cnt_n  = cnt + 1'b1;
        if (cnt == LAST) begin
          state_n = DONE;
          res_n   = prod_n[WIDTH-1:0];
          ovf_n   = |prod_n[2*WIDTH-1:WIDTH];
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      k     <= '0;
      res   <= '0;
    end else begin
      state <= state_n;
      a     <= a_n;
      b     <= b_n;
      k     <= k_n;
      res   <= res_n;
    end
  end

`ifdef COPROC_LCM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode <= 1'b0;
      opa  <= '0;
      opb  <= '0;
      ovf  <= 1'b0;
      g    <= '0;
      rem  <= '0;
      quo  <= '0;
      prod <= '0;
      cnt  <= '0;
    end else begin
      if (accept) begin
        mode <= bus.Mode;
        opa  <= bus.OperandA;
        opb  <= bus.OperandB;
      end
      ovf  <= ovf_n;
      g    <= g_n;
      rem  <= rem_n;
      quo  <= quo_n;
      prod <= prod_n;
      cnt  <= cnt_n;
    end
  end
`endif

endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// Self-checking bench for gcd_lcm_coproc: vector table,
// corner sequences and random ops against an arithmetic model.
module tb_gcd_lcm_coproc;
  localparam int W = 32;
  localparam int BUDGET = 4 * W + 16;
`ifdef COPROC_LCM_EN
  localparam bit LCM_EN = 1'b1;
`else
  localparam bit LCM_EN = 1'b0;
`endif

  typedef struct {
    bit          m;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] g;
    logic [31:0] l;
    bit          lo;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] last_res = '0;
  logic        last_ovf = 1'b0;

  gcd_lcm_coproc_if #(.WIDTH(W)) bus ();

  gcd_lcm_coproc #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] gcd_ref(
      input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [63:0] lcm_ref(
      input logic [31:0] x, input logic [31:0] y);
    logic [63:0] q;
    if (x == 0 || y == 0) return 64'd0;
    q = {32'd0, x / gcd_ref(x, y)};
    return q * {32'd0, y};
  endfunction

  task automatic wait_done(output int lat);
    bit busy_ok;
    bit hold_ok;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    lat = -1;
    for (int c = 1; c <= BUDGET; c++) begin
      if (bus.Done) begin
        lat = c;
        break;
      end
      if (bus.Busy !== 1'b1) busy_ok = 1'b0;
      if (bus.ReadData !== last_res ||
          bus.Overflow !== last_ovf) hold_ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    chk("timeout", 64'(lat > 0), 64'd1);
    chk("busy_in_flight", 64'(busy_ok), 64'd1);
    chk("result_hold", 64'(hold_ok), 64'd1);
  endtask

  task automatic run_op(input bit m,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        output logic [31:0] r,
                        output bit o,
                        output int lat);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Mode = m;
    bus.OperandA = x;
    bus.OperandB = y;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    wait_done(lat);
    r = bus.ReadData;
    o = bus.Overflow;
    last_res = r;
    last_ovf = o;
    @(posedge clk);
    @(negedge clk);
    chk("done_single", 64'(bus.Done), 64'd0);
    chk("busy_after", 64'(bus.Busy), 64'd0);
  endtask

  vec_t tbl[12];
  logic [31:0] r, er, x, y;
  logic [63:0] lm;
  bit o, eo, m;
  int lat, lat_g, lat_l, nd;

  initial begin
    tbl[0]  = '{0, 32'd48, 32'd18, 32'd6, 32'd144, 0};
    tbl[1]  = '{1, 32'd4, 32'd6, 32'd2, 32'd12, 0};
    tbl[2]  = '{0, 32'd0, 32'd7, 32'd7, 32'd0, 0};
    tbl[3]  = '{1, 32'd0, 32'd7, 32'd7, 32'd0, 0};
    tbl[4]  = '{0, 32'd0, 32'd0, 32'd0, 32'd0, 0};
    tbl[5]  = '{1, 32'hFFFFFFFF, 32'hFFFFFFFE,
                32'd1, 32'd2, 1};
    tbl[6]  = '{1, 32'd21, 32'd14, 32'd7, 32'd42, 0};
    tbl[7]  = '{1, 32'd7, 32'd0, 32'd7, 32'd0, 0};
    tbl[8]  = '{0, 32'h80000000, 32'h80000000,
                32'h80000000, 32'h80000000, 0};
    tbl[9]  = '{1, 32'd12, 32'd12, 32'd12, 32'd12, 0};
    tbl[10] = '{1, 32'd48, 32'd18, 32'd6, 32'd144, 0};
    tbl[11] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFE,
                32'd1, 32'd2, 1};

    bus.Start = 1'b0;
    bus.Mode = 1'b0;
    bus.OperandA = '0;
    bus.OperandB = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    chk("rst_data", 64'(bus.ReadData), 64'd0);
    chk("rst_ovf", 64'(bus.Overflow), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].m, tbl[i].a, tbl[i].b, r, o, lat);
      er = (tbl[i].m && LCM_EN) ? tbl[i].l : tbl[i].g;
      eo = (tbl[i].m && LCM_EN) ? tbl[i].lo : 1'b0;
      chk($sformatf("vec%0d_res", i), 64'(r), 64'(er));
      chk($sformatf("vec%0d_ovf", i), 64'(o), 64'(eo));
      if (tbl[i].a == 0 || tbl[i].b == 0)
        chk($sformatf("vec%0d_fastlat", i),
            64'(lat), 64'd1);
    end

    // LCM adds exactly 2*W cycles over the same GCD
    run_op(1'b0, 32'd4, 32'd6, r, o, lat_g);
    chk("gcd_lat_bound", 64'(lat_g <= 2 * W + 2), 64'd1);
    run_op(1'b1, 32'd4, 32'd6, r, o, lat_l);
    chk("lcm_extra_lat", 64'(lat_l - lat_g),
        LCM_EN ? 64'd64 : 64'd0);

    // Start while busy is ignored
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Mode = 1'b0;
    bus.OperandA = 32'd48;
    bus.OperandB = 32'd18;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Mode = 1'b1;
    bus.OperandA = 32'd100;
    bus.OperandB = 32'd75;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    wait_done(lat);
    chk("ign_res", 64'(bus.ReadData), 64'd6);
    chk("ign_ovf", 64'(bus.Overflow), 64'd0);
    last_res = bus.ReadData;
    last_ovf = bus.Overflow;
    nd = 0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.Done) nd++;
    end
    chk("ign_extra_done", 64'(nd), 64'd0);

    // Back-to-back: accept during the DONE cycle
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Mode = 1'b0;
    bus.OperandA = 32'd0;
    bus.OperandB = 32'd7;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_fast_done", 64'(bus.Done), 64'd1);
    chk("b2b_fast_res", 64'(bus.ReadData), 64'd7);
    bus.OperandA = 32'd48;
    bus.OperandB = 32'd18;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    chk("b2b_done_drop", 64'(bus.Done), 64'd0);
    chk("b2b_busy", 64'(bus.Busy), 64'd1);
    last_res = 32'd7;
    last_ovf = 1'b0;
    wait_done(lat);
    chk("b2b_res", 64'(bus.ReadData), 64'd6);
    last_res = bus.ReadData;
    last_ovf = bus.Overflow;
    @(posedge clk);
    @(negedge clk);

    // Reset in the middle of an operation
    bus.Start = 1'b1;
    bus.Mode = 1'b1;
    bus.OperandA = 32'hFFFFFFFF;
    bus.OperandB = 32'hFFFFFFFE;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.Busy), 64'd0);
    chk("mid_rst_done", 64'(bus.Done), 64'd0);
    chk("mid_rst_data", 64'(bus.ReadData), 64'd0);
    chk("mid_rst_ovf", 64'(bus.Overflow), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    last_res = '0;
    last_ovf = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 64'(bus.Done), 64'd0);
    run_op(1'b0, 32'd21, 32'd14, r, o, lat);
    chk("post_rst_gcd", 64'(r), 64'd7);

    for (int i = 0; i < 40; i++) begin
      x = ($urandom >> $urandom_range(0, 24)) *
          $urandom_range(1, 300);
      y = ($urandom >> $urandom_range(0, 24)) *
          $urandom_range(1, 300);
      if ($urandom_range(0, 9) == 0) x = '0;
      m = 1'($urandom_range(0, 1));
      run_op(m, x, y, r, o, lat);
      lm = lcm_ref(x, y);
      er = (m && LCM_EN) ? lm[31:0] : gcd_ref(x, y);
      eo = (m && LCM_EN) ? (lm[63:32] != 0) : 1'b0;
      chk($sformatf("rnd%0d_res", i), 64'(r), 64'(er));
      chk($sformatf("rnd%0d_ovf", i), 64'(o), 64'(eo));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
